ext_bus_sequencer: RTL and testbench

//  Shares the 8-bit external pad bus between two 32-bit requesters: req0 = CPU, req1 = debug/DMA master.

---
 rtl/busseq_pkg.sv | 23 ++
 rtl/busseq_rr_arb.sv | 33 +++
 rtl/ext_bus_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_ext_bus_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/busseq_pkg.sv
// Shared types and constants for ext_bus_sequencer and its round-robin arbiter.
package busseq_pkg;

    localparam int BUSSEQ_DATA_W   = 32;
    localparam int BYTES           = BUSSEQ_DATA_W / 8;
    localparam int BUSSEQ_WAIT_MAX = 15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CMD,
        DATA,
        DONE
    } busseq_state_e;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    function automatic logic [7:0] cmd_byte(input logic we);
        return we ? CMD_WRITE : CMD_READ;
    endfunction

endpackage

// File: rtl/busseq_rr_arb.sv
// Two-way round-robin arbiter; last_grant resets to 1 so requester 0 wins the first tie.
module busseq_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        if (valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ext_bus_sequencer.sv
// Serializes one 32-bit transaction at a time onto the 8-bit pad bus: address bytes, command, data bytes.
// Define BUSSEQ_WAIT_EN to stall DATA bytes on ext_rdy with a per-transaction timeout.
module ext_bus_sequencer
    import busseq_pkg::*;
#(
    parameter int DATA_W   = BUSSEQ_DATA_W,
    parameter int WAIT_MAX = BUSSEQ_WAIT_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [DATA_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [DATA_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [7:0]        pad_out,
    output logic [7:0]        pad_io_out,
    output logic [7:0]        pad_io_oe,
    input  logic [7:0]        pad_io_in,
    input  logic              ext_rdy,
    output busseq_state_e     dbg_state
);

    localparam int         NB   = DATA_W / 8;
    localparam logic [7:0] LAST = 8'(NB - 1);

    busseq_state_e     state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              resp0_q, resp0_d;
    logic              resp1_q, resp1_d;
    logic [7:0]        pad_out_q, pad_out_d;
    logic [7:0]        pad_io_out_q, pad_io_out_d;
    logic [7:0]        pad_io_oe_q, pad_io_oe_d;
    logic              in_idle;
    logic [1:0]        grant;
    logic              accept;

`ifdef BUSSEQ_WAIT_EN
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);
    logic [7:0] wait_cnt_q, wait_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ext_rdy, 32'(WAIT_MAX)};
`endif

    // Handshake: a request transfers on the rising edge where reqN_valid & reqN_ready;
    // ready is only raised in IDLE (and never during reset) for the arbiter winner.
    assign in_idle = rst_n && (state_q == IDLE);

    busseq_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (in_idle ? {req1_valid, req0_valid} : 2'b00),
        .accept (accept),
        .grant  (grant)
    );

    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
        resp0_d      = 1'b0;
        resp1_d      = 1'b0;
        pad_out_d    = 8'h00;
        pad_io_out_d = 8'h00;
        pad_io_oe_d  = 8'h00;
`ifdef BUSSEQ_WAIT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = grant[1];
                    we_d    = grant[1] ? req1_we    : req0_we;
                    addr_d  = grant[1] ? req1_addr  : req0_addr;
                    wdata_d = grant[1] ? req1_wdata : req0_wdata;
                    cnt_d   = 8'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (cnt_q == LAST) begin
                    cnt_d   = 8'd0;
                    state_d = CMD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CMD: begin
                cnt_d   = 8'd0;
                state_d = DATA;
`ifdef BUSSEQ_WAIT_EN
                wait_cnt_d = 8'd0;
`endif
            end
            DATA: begin
`ifdef BUSSEQ_WAIT_EN
                if (!ext_rdy) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == WAIT_LIM) begin
                        state_d    = DONE;
                        resp_err_d = 1'b1;
                    end
                end else
`endif
                begin
                    for (int k = 0; k < NB; k++) begin
                        if (!we_q && cnt_q == 8'(k)) begin
                            rbuf_d[8*k +: 8] = pad_io_in;
                        end
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        if (!we_q) begin
                            resp_rdata_d = rbuf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pads and the response pulse are registered from next-state values so they line up with the phase.
        if (state_d == DONE) begin
            resp0_d = ~owner_q;
            resp1_d = owner_q;
        end
        if (state_d == ADDR) begin
            for (int k = 0; k < NB; k++) begin
                if (cnt_d == 8'(k)) begin
                    pad_out_d = addr_d[8*k +: 8];
                    if (we_d) begin
                        pad_io_out_d = wdata_d[8*k +: 8];
                        pad_io_oe_d  = 8'hFF;
                    end
                end
            end
        end else if (state_d == CMD) begin
            pad_out_d = cmd_byte(we_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp0_q      <= 1'b0;
            resp1_q      <= 1'b0;
            pad_out_q    <= 8'h00;
            pad_io_out_q <= 8'h00;
            pad_io_oe_q  <= 8'h00;
`ifdef BUSSEQ_WAIT_EN
            wait_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
            pad_out_q    <= pad_out_d;
            pad_io_out_q <= pad_io_out_d;
            pad_io_oe_q  <= pad_io_oe_d;
`ifdef BUSSEQ_WAIT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign resp0_valid = resp0_q;
    assign resp1_valid = resp1_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign pad_out     = pad_out_q;
    assign pad_io_out  = pad_io_out_q;
    assign pad_io_oe   = pad_io_oe_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Bench for ext_bus_sequencer: transaction-level model checked every cycle plus directed literal checks.
module tb_ext_bus_sequencer;
    import busseq_pkg::*;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v[2];
    logic        we_a[2];
    logic [31:0] addr_a[2];
    logic [31:0] wd_a[2];
    logic        r0, r1, p0, p1, resp_err, ext_rdy;
    logic [31:0] resp_rdata;
    logic [7:0]  pad_out, pad_io_out, pad_io_oe, pad_io_in;
    busseq_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_cnt[2];
    logic acc_seen[2];
    logic model_on;

    // model of the transaction in flight, kept in plain per-transaction terms
    logic        m_busy, m_last, m_owner, m_we;
    int          m_start;
    logic [31:0] m_addr, m_wdata, m_rbuf, m_rdata;

    always #5 clk = ~clk;

    ext_bus_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (v[0]),
        .req0_ready (r0),
        .req0_we    (we_a[0]),
        .req0_addr  (addr_a[0]),
        .req0_wdata (wd_a[0]),
        .req1_valid (v[1]),
        .req1_ready (r1),
        .req1_we    (we_a[1]),
        .req1_addr  (addr_a[1]),
        .req1_wdata (wd_a[1]),
        .resp0_valid(p0),
        .resp1_valid(p1),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .pad_out    (pad_out),
        .pad_io_out (pad_io_out),
        .pad_io_oe  (pad_io_oe),
        .pad_io_in  (pad_io_in),
        .ext_rdy    (ext_rdy),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic we, input logic [31:0] a, input logic [31:0] d);
        v[n]      = 1'b1;
        we_a[n]   = we;
        addr_a[n] = a;
        wd_a[n]   = d;
    endtask

    // Compare process: model and DUT side by side at every falling edge.
    always @(negedge clk) begin
        logic [1:0] exp_r, exp_p;
        logic [7:0] e_out, e_io, e_oe;
        int t;
        cyc++;
        acc_seen[0] = v[0] & r0;
        acc_seen[1] = v[1] & r1;
        if (p0) resp_cnt[0]++;
        if (p1) resp_cnt[1]++;
        if (!rst_n) begin
            chk("rst_ready", 32'({r1, r0}), 32'd0);
            chk("rst_resp", 32'({p1, p0, resp_err}), 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
            chk("rst_pads", 32'({pad_out, pad_io_out, pad_io_oe}), 32'd0);
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_rdata = 32'd0;
        end else if (model_on) begin
            exp_r = 2'b00;
            exp_p = 2'b00;
            e_out = 8'h00;
            e_io  = 8'h00;
            e_oe  = 8'h00;
            if (!m_busy) begin
                if (v[0] && v[1]) exp_r = m_last ? 2'b01 : 2'b10;
                else              exp_r = {v[1], v[0]};
                if (exp_r != 2'b00) begin
                    m_busy  = 1'b1;
                    m_start = cyc;
                    m_owner = exp_r[1];
                    m_we    = we_a[m_owner];
                    m_addr  = addr_a[m_owner];
                    m_wdata = wd_a[m_owner];
                    m_last  = m_owner;
                end
            end else begin
                t = cyc - m_start;
                if (t >= 1 && t <= NB) begin
                    e_out = m_addr[8*(t-1) +: 8];
                    if (m_we) begin
                        e_io = m_wdata[8*(t-1) +: 8];
                        e_oe = 8'hFF;
                    end
                end else if (t == NB + 1) begin
                    e_out = {7'b0, m_we};
                end else if (t <= 2*NB + 1) begin
                    if (!m_we) m_rbuf[8*(t-NB-2) +: 8] = pad_io_in;
                end else begin
                    exp_p[m_owner] = 1'b1;
                    if (!m_we) m_rdata = m_rbuf;
                    m_busy = 1'b0;
                end
            end
            chk("ready", 32'({r1, r0}), 32'(exp_r));
            chk("resp_valid", 32'({p1, p0}), 32'(exp_p));
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", 32'(resp_err), 32'd0);
            chk("pad_out", 32'(pad_out), 32'(e_out));
            chk("pad_io_out", 32'(pad_io_out), 32'(e_io));
            chk("pad_io_oe", 32'(pad_io_oe), 32'(e_oe));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd_pad[5]  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
        logic [7:0] rd_io[4]   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        logic [7:0] wr_io[4]   = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        logic [7:0] wr_pad[5]  = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01};
        logic       rr_exp[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        int         left[2];
        logic       found, who, acc;

        v[0] = 1'b0; v[1] = 1'b0;
        we_a[0] = 1'b0; we_a[1] = 1'b0;
        addr_a[0] = '0; addr_a[1] = '0;
        wd_a[0] = '0; wd_a[1] = '0;
        resp_cnt[0] = 0; resp_cnt[1] = 0;
        acc_seen[0] = 1'b0; acc_seen[1] = 1'b0;
        m_busy = 1'b0; m_last = 1'b1; m_rdata = '0; m_rbuf = '0;
        model_on  = 1'b1;
        ext_rdy   = 1'b1;
        pad_io_in = 8'h00;
        rst_n     = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst_n = 1'b1;
        tick();

        // directed read from requester 0
        set_req(0, 1'b0, 32'h1234_5678, 32'h0);
        @(negedge clk);
        chk("rd_accept", 32'(r0), 32'd1);
        tick();
        v[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rd_pad_out", 32'(pad_out), 32'(rd_pad[k]));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            pad_io_in = rd_io[k];
            tick();
        end
        pad_io_in = 8'h00;
        @(negedge clk);
        chk("rd_resp0_at_10", 32'(p0), 32'd1);
        chk("rd_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("rd_err", 32'(resp_err), 32'd0);
        tick();

        // directed write from requester 1
        set_req(1, 1'b1, 32'h0000_0004, 32'hCAFE_F00D);
        @(negedge clk);
        chk("wr_accept", 32'(r1), 32'd1);
        tick();
        v[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("wr_pad_out", 32'(pad_out), 32'(wr_pad[k]));
            if (k < 4) begin
                chk("wr_io_out", 32'(pad_io_out), 32'(wr_io[k]));
                chk("wr_io_oe", 32'(pad_io_oe), 32'hFF);
            end
            tick();
        end
        repeat (4) tick();
        @(negedge clk);
        chk("wr_resp1", 32'(p1), 32'd1);
        chk("wr_rdata_held", resp_rdata, 32'hDEAD_BEEF);
        tick();

`ifdef BUSSEQ_WAIT_EN
        // read with ext_rdy held low must abort after the stall limit
        model_on = 1'b0;
        ext_rdy  = 1'b0;
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        v[0] = 1'b0;
        found = 1'b0;
        for (int lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            if (p0) begin
                found = 1'b1;
                chk("to_latency", 32'(lat), 32'(NB + 2 + BUSSEQ_WAIT_MAX));
                chk("to_err", 32'(resp_err), 32'd1);
                chk("to_rdata_held", resp_rdata, 32'hDEAD_BEEF);
                break;
            end
            tick();
        end
        chk("to_resp_seen", 32'(found), 32'd1);
        tick();
        ext_rdy = 1'b1;
`endif

        // reset during DATA byte 2, with a request waiting on requester 1
        set_req(0, 1'b0, 32'hA5A5_0001, 32'h0);
        tick();
        v[0] = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        set_req(1, 1'b0, 32'h0BAD_0000, 32'h0);
        @(negedge clk);
        chk("midrst_ready1", 32'(r1), 32'd0);
        chk("midrst_pad_out", 32'(pad_out), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst_n    = 1'b1;
        model_on = 1'b1;
        found = 1'b0;
        acc   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r1) acc = 1'b1;
            if (p1) begin
                found = 1'b1;
                chk("postrst_rdata", resp_rdata, 32'd0);
                break;
            end
            if (p0) chk("postrst_no_resp0", 32'(p0), 32'd0);
            tick();
            if (acc) v[1] = 1'b0;
        end
        chk("postrst_resp1", 32'(found), 32'd1);
        tick();
        v[1] = 1'b0;

        // both requesters valid continuously: grants alternate starting with 0
        set_req(0, 1'b0, 32'h1111_0000, 32'h0);
        set_req(1, 1'b1, 32'h2222_0000, 32'h3333_4444);
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            who   = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (r0 || r1) begin
                    found = 1'b1;
                    who   = r1;
                    chk("rr_not_both", 32'(r0 & r1), 32'd0);
                    break;
                end
                tick();
            end
            chk("rr_found", 32'(found), 32'd1);
            chk("rr_order", 32'(who), 32'(rr_exp[g]));
            tick();
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        repeat (12) tick();

        // random traffic from both requesters against the model
        resp_cnt[0] = 0;
        resp_cnt[1] = 0;
        left[0] = 12;
        left[1] = 12;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if (v[n] && acc_seen[n]) begin
                    v[n] = 1'b0;
                    left[n]--;
                end
                if (!v[n] && left[n] > 0 && $urandom_range(0, 3) == 0) begin
                    set_req(n, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
            pad_io_in = 8'($urandom_range(0, 255));
            if (left[0] == 0 && left[1] == 0) break;
        end
        repeat (2*NB + 4) tick();
        chk("rand_all_accepted", 32'(left[0] + left[1]), 32'd0);
        chk("rand_resp0_count", 32'(resp_cnt[0]), 32'd12);
        chk("rand_resp1_count", 32'(resp_cnt[1]), 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
